// File: rtl/pxs_pkg.sv
// Shared stream-layout constants for the pixel stream blocks.
// Field offsets and the packed stream width derive from COORD_W and CW.
package pxs_pkg;
  localparam int AV_OFS = 0;
  localparam int VS_OFS = 1;
  localparam int HS_OFS = 2;
  localparam int Y_OFS  = 3;

  localparam logic SYNC_ACT_LOW  = 1'b0;
  localparam logic SYNC_ACT_HIGH = 1'b1;

  function automatic int x_ofs(input int coord_w);
    return Y_OFS + coord_w;
  endfunction

  function automatic int b_ofs(input int coord_w);
    return Y_OFS + 2*coord_w;
  endfunction

  function automatic int g_ofs(input int coord_w, input int cw);
    return b_ofs(coord_w) + cw;
  endfunction

  function automatic int r_ofs(input int coord_w, input int cw);
    return b_ofs(coord_w) + 2*cw;
  endfunction

  function automatic int str_w(input int coord_w, input int cw);
    return 3*cw + 2*coord_w + 3;
  endfunction
endpackage

// File: rtl/pxs_str_dly.sv
// Clock-enabled register chain of DEPTH words; each stage loads rst_val on reset.
module pxs_str_dly #(
  parameter int W     = 26,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] stg [DEPTH+1];

  assign stg[0] = din;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)  stg[i+1] <= rst_val;
      else if (ce) stg[i+1] <= stg[i];
  end

  assign dout = stg[DEPTH];
endmodule

// File: rtl/pxs_str_unpack.sv
// Delays and unpacks a packed pixel stream, blank-masks colour and flags sync edges.
// Optional frame counter enabled by defining PXS_FRAME_CNT_EN.
module pxs_str_unpack
  import pxs_pkg::*;
#(
  parameter int   COORD_W  = 10,
  parameter int   CW       = 1,
  parameter int   DELAY    = 1,
  parameter logic SYNC_POL = SYNC_ACT_LOW,
  parameter int   FCW      = 8,
  localparam int  SW       = str_w(COORD_W, CW)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_ce,
  input  logic [SW-1:0]      str_i,
  output logic               HSync,
  output logic               VSync,
  output logic [CW-1:0]      Red,
  output logic [CW-1:0]      Green,
  output logic [CW-1:0]      Blue,
  output logic [COORD_W-1:0] XCoord,
  output logic [COORD_W-1:0] YCoord,
  output logic               ActiveVideo,
  output logic               line_start,
  output logic               frame_start
`ifdef PXS_FRAME_CNT_EN
  ,
  output logic [FCW-1:0]     frame_cnt
`endif
);
  localparam int XO = x_ofs(COORD_W);
  localparam int BO = b_ofs(COORD_W);
  localparam int GO = g_ofs(COORD_W, CW);
  localparam int RO = r_ofs(COORD_W, CW);
  localparam logic [SW-1:0] RST_WORD = {{(SW-3){1'b0}}, ~SYNC_POL, ~SYNC_POL, 1'b0};

  if (DELAY < 1 || DELAY > 8 || FCW < 1) begin : g_bad_param
    $error("pxs_str_unpack: DELAY must be 1..8 and FCW >= 1");
  end

  logic [SW-1:0] q;

  pxs_str_dly #(.W(SW), .DEPTH(DELAY)) u_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (pix_ce),
    .rst_val (RST_WORD),
    .din     (str_i),
    .dout    (q)
  );

  assign ActiveVideo = q[AV_OFS];
  assign VSync       = q[VS_OFS];
  assign HSync       = q[HS_OFS];
  assign YCoord      = q[Y_OFS +: COORD_W];
  assign XCoord      = q[XO +: COORD_W];
  assign Blue        = ActiveVideo ? q[BO +: CW] : '0;
  assign Green       = ActiveVideo ? q[GO +: CW] : '0;
  assign Red         = ActiveVideo ? q[RO +: CW] : '0;

  // hist holds the output syncs from before the last shift; shifted marks
  // the single clk following an enabled edge, so each edge pulses once.
  logic hs_hist, vs_hist, shifted;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hs_hist <= ~SYNC_POL;
      vs_hist <= ~SYNC_POL;
      shifted <= 1'b0;
    end else begin
      shifted <= pix_ce;
      if (pix_ce) begin
        hs_hist <= HSync;
        vs_hist <= VSync;
      end
    end

  assign line_start  = shifted && (HSync == SYNC_POL) && (hs_hist != SYNC_POL);
  assign frame_start = shifted && (VSync == SYNC_POL) && (vs_hist != SYNC_POL);

`ifdef PXS_FRAME_CNT_EN
  // Count is already advanced during the frame_start clk.
  logic [FCW-1:0] cnt_q;

  assign frame_cnt = cnt_q + FCW'(frame_start);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= frame_cnt;
`endif
endmodule

// File: tb/tb_pxs_str_unpack.sv
// Scoreboard bench for pxs_str_unpack: queue-based stream model, per-clk checking.
module tb_pxs_str_unpack;
  localparam int   COORD_W = 10;
  localparam int   CW      = 1;
  localparam int   DELAY   = 3;
  localparam logic SP      = 1'b0;
  localparam int   FCW     = 2;
  localparam int   SW      = 3*CW + 2*COORD_W + 3;
  localparam int   BO      = 3 + 2*COORD_W;
  localparam logic [SW-1:0] RST_W = {{(SW-3){1'b0}}, ~SP, ~SP, 1'b0};

  typedef struct packed {
    logic [SW-1:0]  w;
    logic           ls;
    logic           fs;
    logic [FCW-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_ce = 1'b0;
  logic [SW-1:0] str_i = '0;
  logic HSync, VSync, ActiveVideo, line_start, frame_start;
  logic [CW-1:0] Red, Green, Blue;
  logic [COORD_W-1:0] XCoord, YCoord;
`ifdef PXS_FRAME_CNT_EN
  logic [FCW-1:0] frame_cnt;
`endif

  int checks = 0;
  int failures = 0;

  exp_t          exp_q[$];
  logic [SW-1:0] pipe[$];
  logic [FCW-1:0] fcnt;

  pxs_str_unpack #(.COORD_W(COORD_W), .CW(CW), .DELAY(DELAY), .SYNC_POL(SP), .FCW(FCW)) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .str_i(str_i),
    .HSync(HSync), .VSync(VSync), .Red(Red), .Green(Green), .Blue(Blue),
    .XCoord(XCoord), .YCoord(YCoord), .ActiveVideo(ActiveVideo),
    .line_start(line_start), .frame_start(frame_start)
`ifdef PXS_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [SW+1:0] exp_vec(input exp_t e);
    logic [SW-1:0] w;
    w = e.w;
    if (!w[0]) w[SW-1:BO] = '0;
    return {w, e.ls, e.fs};
  endfunction

  function automatic logic [SW+1:0] dut_vec();
    return {Red, Green, Blue, XCoord, YCoord, HSync, VSync, ActiveVideo, line_start, frame_start};
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e.w = RST_W; e.ls = 1'b0; e.fs = 1'b0; e.fc = '0;
    return e;
  endfunction

  function automatic void model_reset();
    pipe.delete();
    for (int i = 0; i < DELAY; i++) pipe.push_back(RST_W);
    fcnt = '0;
  endfunction

  // Model: queue of captured words, front is what the outputs show.
  initial begin
    logic [SW-1:0] old_w, new_w;
    exp_t e;
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
        exp_q.push_back(rst_exp());
      end else begin
        e.ls = 1'b0; e.fs = 1'b0;
        if (pix_ce) begin
          old_w = pipe.pop_front();
          pipe.push_back(str_i);
          new_w = pipe[0];
          e.ls = (new_w[2] == SP) && (old_w[2] != SP);
          e.fs = (new_w[1] == SP) && (old_w[1] != SP);
          if (e.fs) fcnt = fcnt + 1'b1;
        end
        e.w = pipe[0];
        e.fc = fcnt;
        exp_q.push_back(e);
      end
    end
  end

  // Asynchronous reset replaces whatever the current clk was expected to show.
  initial forever begin
    @(negedge rst_n);
    model_reset();
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = rst_exp();
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (dut_vec() !== exp_vec(e)) begin
        failures++;
        $display("FAIL stream t=%0t got=%h exp=%h", $time, dut_vec(), exp_vec(e));
      end
`ifdef PXS_FRAME_CNT_EN
      checks++;
      if (frame_cnt !== e.fc) begin
        failures++;
        $display("FAIL frame_cnt t=%0t got=%0d exp=%0d", $time, frame_cnt, e.fc);
      end
`endif
    end
  end

  task automatic drive(input logic ce, input logic [SW-1:0] w);
    @(posedge clk);
    #1;
    pix_ce = ce;
    str_i  = w;
  endtask

  task automatic check_reset_now(input string name);
    checks++;
    if (dut_vec() !== exp_vec(rst_exp())) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, dut_vec(), exp_vec(rst_exp()));
    end
  endtask

  function automatic logic [SW-1:0] mk(input logic hs, input logic vs, input logic av);
    logic [SW-1:0] w;
    w = SW'($urandom);
    w[2] = hs; w[1] = vs; w[0] = av;
    return w;
  endfunction

  initial begin
    logic hs, vs;
    logic [SW-1:0] w;
    repeat (3) @(posedge clk);
    #1 check_reset_now("reset_state");
    #2 rst_n = 1'b1;

    // Reference word through DELAY enabled shifts, then a held cycle.
    drive(1'b1, 26'h2AAAAAD);
    drive(1'b1, RST_W);
    drive(1'b1, RST_W);
    drive(1'b0, RST_W);
    checks++;
    if ({Red, Green, Blue, XCoord, YCoord, HSync, VSync, ActiveVideo} !==
        {1'b1, 1'b0, 1'b1, 10'h155, 10'h155, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL ref_word got=%h exp=%h",
               {Red, Green, Blue, XCoord, YCoord, HSync, VSync, ActiveVideo},
               {1'b1, 1'b0, 1'b1, 10'h155, 10'h155, 1'b1, 1'b0, 1'b1});
    end

    // Sparse enable pattern.
    drive(1'b1, mk(1'b1, 1'b1, 1'b1));
    drive(1'b0, mk(1'b1, 1'b1, 1'b1));
    drive(1'b1, mk(1'b1, 1'b1, 1'b1));
    drive(1'b0, mk(1'b1, 1'b1, 1'b1));
    drive(1'b1, mk(1'b1, 1'b1, 1'b1));
    repeat (4) drive(1'b0, RST_W);

    // Blanked word with all colour bits set.
    w = mk(1'b1, 1'b1, 1'b0);
    w[SW-1:BO] = '1;
    drive(1'b1, w);
    repeat (DELAY) drive(1'b1, mk(1'b1, 1'b1, 1'b1));

    // VSync inactive, active for 3, inactive; single-cycle HSync assertion.
    drive(1'b1, mk(1'b1, 1'b1, 1'b1));
    repeat (3) drive(1'b1, mk(1'b1, 1'b0, 1'b1));
    drive(1'b1, mk(1'b0, 1'b1, 1'b1));
    repeat (DELAY + 2) drive(1'b1, mk(1'b1, 1'b1, 1'b1));

    // Randomised traffic with sync runs; mid-line reset with a full pipeline.
    hs = 1'b1; vs = 1'b1;
    for (int n = 0; n < 1600; n++) begin
      if ($urandom_range(0, 7) == 0)  hs = ~hs;
      if ($urandom_range(0, 15) == 0) vs = ~vs;
      drive(($urandom_range(0, 3) != 0), mk(hs, vs, 1'($urandom)));
      if (n == 800) begin
        repeat (DELAY + 1) drive(1'b1, mk(hs, vs, 1'b1));
        #1 rst_n = 1'b0;
        #1 check_reset_now("async_reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        drive(1'b1, mk(1'b0, 1'b0, 1'b1));
      end
    end

    repeat (DELAY + 2) drive(1'b1, RST_W);
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
